// File: rtl/nuke_anim_scheduler.sv
// Round-robin arbiter that lends the single base-explosion renderer to one base at a time.
// Define NUKE_FINALE_EN to play a finale animation before game_over asserts.
module nuke_anim_scheduler #(
  parameter int N_BASES       = 4,
  parameter int IDX_WIDTH     = 2,
  parameter int ANIM_FRAMES   = 3,
  parameter int FINALE_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [N_BASES-1:0]   base_nuked,
  output logic                 anim_start,
  output logic                 anim_active,
  output logic [IDX_WIDTH-1:0] anim_idx,
  output logic [3:0]           anim_frame,
  output logic                 anim_done,
  output logic [4:0]           nuked_count,
  output logic                 game_over
);

  if (N_BASES < 2 || N_BASES > 16 || ANIM_FRAMES < 1 || ANIM_FRAMES > 15 ||
      FINALE_FRAMES < 1 || (1 << IDX_WIDTH) < N_BASES) begin : g_bad_params
    $error("nuke_anim_scheduler: illegal parameter combination");
  end

`ifdef NUKE_FINALE_EN
  typedef enum logic [2:0] {IDLE, ANIMATE, DONE, GAMEOVER, FINALE} state_t;
  logic [7:0] finale_cnt, finale_cnt_next;
`else
  typedef enum logic [2:0] {IDLE, ANIMATE, DONE, GAMEOVER} state_t;
`endif

  localparam logic [N_BASES-1:0] ALL_SERVED = {N_BASES{1'b1}};
  localparam logic [3:0]         LAST_FRAME = 4'(ANIM_FRAMES - 1);

  state_t                 state, state_next;
  logic [N_BASES-1:0]     pending, pending_next;
  logic [N_BASES-1:0]     served, served_next;
  logic [IDX_WIDTH-1:0]   rr_last, rr_last_next;
  logic                   anim_start_next, anim_active_next, anim_done_next, game_over_next;
  logic [IDX_WIDTH-1:0]   anim_idx_next;
  logic [3:0]             anim_frame_next;
  logic [4:0]             nuked_count_next;

  logic [N_BASES-1:0]     masked;
  logic                   found, found_hi;
  logic [IDX_WIDTH-1:0]   pick, pick_hi, pick_any;

  assign masked = (pending | base_nuked) & ~served;

  // Lowest requester above rr_last wins; otherwise wrap to the lowest overall.
  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_any = '0;
    for (int j = N_BASES - 1; j >= 0; j--) begin
      if (masked[j]) begin
        pick_any = IDX_WIDTH'(j);
        if (j > int'(rr_last)) begin
          pick_hi  = IDX_WIDTH'(j);
          found_hi = 1'b1;
        end
      end
    end
    found = |masked;
    pick  = found_hi ? pick_hi : pick_any;
  end

  always_comb begin
    state_next       = state;
    pending_next     = masked;
    served_next      = served;
    rr_last_next     = rr_last;
    anim_start_next  = 1'b0;
    anim_done_next   = 1'b0;
    anim_active_next = anim_active;
    anim_idx_next    = anim_idx;
    anim_frame_next  = anim_frame;
    nuked_count_next = nuked_count;
    game_over_next   = game_over;
`ifdef NUKE_FINALE_EN
    finale_cnt_next  = finale_cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_next        = ANIMATE;
          anim_idx_next     = pick;
          rr_last_next      = pick;
          served_next       = served | (N_BASES'(1) << pick);
          anim_start_next   = 1'b1;
          anim_active_next  = 1'b1;
          anim_frame_next   = 4'd0;
          if (nuked_count < 5'(N_BASES))
            nuked_count_next = nuked_count + 5'd1;
        end
      end
      ANIMATE: begin
        if (frame_tick) begin
          if (anim_frame == LAST_FRAME) begin
            state_next       = DONE;
            anim_done_next   = 1'b1;
            anim_active_next = 1'b0;
            anim_frame_next  = 4'd0;
          end else begin
            anim_frame_next  = anim_frame + 4'd1;
          end
        end
      end
      DONE: begin
        if (served == ALL_SERVED) begin
`ifdef NUKE_FINALE_EN
          state_next       = FINALE;
          anim_active_next = 1'b1;
          anim_idx_next    = IDX_WIDTH'(N_BASES - 1);
          anim_frame_next  = 4'd0;
          finale_cnt_next  = 8'd0;
`else
          state_next       = GAMEOVER;
          game_over_next   = 1'b1;
`endif
        end else begin
          state_next = IDLE;
        end
      end
`ifdef NUKE_FINALE_EN
      FINALE: begin
        if (frame_tick) begin
          if (anim_frame != 4'd15)
            anim_frame_next = anim_frame + 4'd1;
          if (finale_cnt == 8'(FINALE_FRAMES - 1)) begin
            state_next       = GAMEOVER;
            game_over_next   = 1'b1;
            anim_done_next   = 1'b1;
            anim_active_next = 1'b0;
          end else begin
            finale_cnt_next  = finale_cnt + 8'd1;
          end
        end
      end
`endif
      GAMEOVER: begin
        pending_next = pending;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      served      <= '0;
      rr_last     <= IDX_WIDTH'(N_BASES - 1);
      anim_start  <= 1'b0;
      anim_active <= 1'b0;
      anim_idx    <= '0;
      anim_frame  <= 4'd0;
      anim_done   <= 1'b0;
      nuked_count <= 5'd0;
      game_over   <= 1'b0;
`ifdef NUKE_FINALE_EN
      finale_cnt  <= 8'd0;
`endif
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      served      <= served_next;
      rr_last     <= rr_last_next;
      anim_start  <= anim_start_next;
      anim_active <= anim_active_next;
      anim_idx    <= anim_idx_next;
      anim_frame  <= anim_frame_next;
      anim_done   <= anim_done_next;
      nuked_count <= nuked_count_next;
      game_over   <= game_over_next;
`ifdef NUKE_FINALE_EN
      finale_cnt  <= finale_cnt_next;
`endif
    end
  end

endmodule

// File: doc/nuke_anim_scheduler.md
Name: nuke_anim_scheduler

Overview:
- Shares the single base-explosion animation renderer between N_BASES base controllers.
- Each base controller raises a level `base_nuked` flag. This block latches those flags as sticky requests and grants the renderer round-robin, one base at a time.
- It times each explosion in frame ticks, counts destroyed bases, and flags game over once every base has been nuked and animated.
- It sits between the per-base controllers and the explosion sprite/draw stage.

Parameters:
- N_BASES, 4, number of bases / requesters (2..16).
- IDX_WIDTH, 2, width of the base index; must be >= ceil(log2(N_BASES)).
- ANIM_FRAMES, 3, explosion duration in frame_tick pulses (1..15).
- FINALE_FRAMES, 8, duration of the finale animation in frame_tick pulses (optional feature only).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- frame_tick, input, 1, one-cycle pulse per video frame.
- base_nuked, input, N_BASES, level flag per base (bit i = base i).
- anim_start, output, 1, one-cycle pulse when a new explosion begins.
- anim_active, output, 1, high while the renderer is owned by a base.
- anim_idx, output, IDX_WIDTH, index of the base being animated.
- anim_frame, output, 4, current explosion frame (0..ANIM_FRAMES-1).
- anim_done, output, 1, one-cycle pulse at the end of an explosion.
- nuked_count, output, 5, number of bases granted so far.
- game_over, output, 1, sticky all-bases-destroyed flag.

Behaviour:
- Reset is synchronous and active-high: reset rst, synchronous, active-high; clock clk.
- All outputs and state are registered.
- Reset values:
  - state = IDLE.
  - pending = 0, served = 0.
  - rr_last = N_BASES-1, so base 0 has first priority.
  - anim_start = anim_active = anim_done = game_over = 0.
  - anim_idx = 0, anim_frame = 0, nuked_count = 0.
- Request latching, every cycle outside reset: pending <= (pending | base_nuked) & ~served.
  - Requests are sticky; base_nuked dropping after one cycle is still served.
  - A served base never re-requests.
- States:
  - IDLE, ANIMATE, DONE, GAMEOVER. FINALE exists only with the optional feature.
- IDLE:
  - If the masked request vector (pending|base_nuked)&~served is non-zero, pick the first set bit searching from rr_last+1 upward, wrapping modulo N_BASES.
  - Next cycle: anim_idx = pick, rr_last = pick, served[pick] = 1, nuked_count += 1, anim_start = 1 (single cycle), anim_active = 1, anim_frame = 0, state = ANIMATE.
  - Grant latency: a request asserted in cycle T starts its animation in cycle T+1 when the scheduler is idle.
  - frame_tick is ignored in IDLE.
- ANIMATE:
  - On frame_tick with anim_frame < ANIM_FRAMES-1: anim_frame += 1.
  - On frame_tick with anim_frame == ANIM_FRAMES-1: state = DONE and anim_done = 1 for one cycle.
  - anim_active stays high and anim_idx stays stable throughout.
  - New requests arriving during ANIMATE are queued in pending and are never pre-empting.
- DONE, one cycle:
  - anim_active = 0 and anim_frame = 0.
  - If served is all ones: state = GAMEOVER and game_over = 1.
  - Otherwise: state = IDLE.
  - Back-to-back grants are therefore separated by exactly 2 idle cycles (DONE, IDLE).
- GAMEOVER:
  - Terminal state; exited only by rst.
  - game_over = 1; all further inputs ignored.
- Simultaneous requests:
  - Served in round-robin order from rr_last+1.
  - Example: rr_last = 1 with requests {0,2,3} gives the order 2, 3, 0.
- Width rules:
  - nuked_count saturates at N_BASES; it never exceeds N_BASES by construction.
  - anim_frame is 4 bits, zero-extended.
- Reset mid-animation:
  - All state clears on the next edge.
  - Bases still holding base_nuked are re-latched on the following cycle and animated again from frame 0.

Optional Feature:
- Macro: NUKE_FINALE_EN.
- Defined:
  - DONE with all bases served enters FINALE instead of GAMEOVER.
  - In FINALE: anim_active = 1 and anim_idx = N_BASES-1; anim_frame counts frame_tick pulses and saturates at 15.
  - After FINALE_FRAMES ticks: go to GAMEOVER, assert game_over, and pulse anim_done once more.
- Undefined:
  - No FINALE state exists; game_over asserts in the cycle after the last DONE.

Test Plan:
- Reset, then base_nuked = 4'b0100 for 1 cycle.
  - Expect anim_start pulse with anim_idx = 2 one cycle later, anim_frame 0→1→2 on 3 frame_ticks, then anim_done.
  - Expect nuked_count = 1, game_over = 0.
- base_nuked = 4'b1011 held from reset.
  - Expect grant order 0, 1, 3; nuked_count 1, 2, 3.
  - Expect exactly 2 cycles with anim_active = 0 between grants; game_over stays 0.
- During base 0's animation, assert base_nuked[3] for a single cycle.
  - Expect no pre-emption; base 3 is granted in the IDLE cycle after DONE.
- All four bases nuked.
  - Expect game_over = 1 one cycle after the 4th anim_done and nuked_count = 4.
  - Further frame_ticks and base_nuked produce no further anim_start.
- Assert rst while anim_frame = 1 with base_nuked[1] still high.
  - Expect outputs cleared at the next edge, then re-grant of base 1 with anim_frame = 0 and nuked_count = 1.
- With NUKE_FINALE_EN defined, nuke all bases.
  - Expect anim_active to remain high for FINALE_FRAMES (8) frame_ticks after the last anim_done.
  - Expect game_over = 1 only after those 8 ticks.
